// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - operand forwarding selects and load-use stall control
// Tracks EX/MEM/WB in a shadow pipeline and counts stall cycles.
module hazard_forward_unit #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_BITS     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid_i,
  input  logic [4:0]          id_rs_i,
  input  logic [4:0]          id_rt_i,
  input  logic [4:0]          id_rd_i,
  input  logic                id_regwrite_i,
  input  logic                id_memread_i,
  input  logic                flush_i,
  output logic [1:0]          forward_a_o,
  output logic [1:0]          forward_b_o,
  output logic                stall_o,
  output logic [CNT_BITS-1:0] stall_count_o
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } slot_t;

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [2:0] STALL_INIT = 3'(STALL_CYCLES - 1);

  slot_t  id_slot;
  slot_t  ex_q;
  slot_t  mem_q;
  slot_t  wb_q;
  state_t state_q;
  logic [2:0] cnt_q;
  logic   hazard;
  logic   unused_wb_fields;

  assign id_slot = '{valid: id_valid_i, rs: id_rs_i, rt: id_rt_i, rd: id_rd_i,
                     regwrite: id_regwrite_i, memread: id_memread_i};

  // WB only supplies its destination for forwarding; sources are carried along for visibility.
  assign unused_wb_fields = ^{wb_q.rs, wb_q.rt, wb_q.memread};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= (stall_o || flush_i) ? slot_t'('0) : id_slot;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input slot_t mem_s,
                                         input slot_t wb_s);
    if (mem_s.valid && mem_s.regwrite && (mem_s.rd != 5'd0) && (mem_s.rd == src))
      return 2'b10;
    else if (wb_s.valid && wb_s.regwrite && (wb_s.rd != 5'd0) && (wb_s.rd == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    forward_a_o = 2'b00;
    forward_b_o = 2'b00;
    if (ex_q.valid) begin
      forward_a_o = fwd_sel(ex_q.rs, mem_q, wb_q);
      forward_b_o = fwd_sel(ex_q.rt, mem_q, wb_q);
    end
  end

  assign hazard = id_valid_i & ex_q.valid & ex_q.memread & ex_q.regwrite &
                  (ex_q.rd != 5'd0) & ((ex_q.rd == id_rs_i) | (ex_q.rd == id_rt_i));

  // Mealy stall: a flush always wins, so the squashed ID instruction never holds the PC.
  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      RUN:     stall_o = hazard & ~flush_i;
      STALL:   stall_o = ~flush_i;
      default: stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else if (flush_i) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (stall_o && (STALL_CYCLES > 1)) begin
            state_q <= STALL;
            cnt_q   <= STALL_INIT;
          end
        end
        STALL: begin
          if (cnt_q == 3'd1) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count_o <= '0;
    else if (stall_o && (stall_count_o != {CNT_BITS{1'b1}}))
      stall_count_o <= stall_count_o + CNT_BITS'(1);
  end

endmodule
